// File: rtl/wb_retire_unit_if.sv
// Handshake and bus bundle for wb_retire_unit: the instruction input side,
// the register-file write port, the PC redirect and the status outputs.
interface wb_retire_unit_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [5:0]         in_op;
    logic               in_ife;
    logic [RADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]  in_data;
    logic               reg_update;
    logic [RADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]  reg_new;
    logic               reg_ack;
    logic               pc_update;
    logic [DATA_W-1:0]  pc_new;
    logic [CNT_W-1:0]   retire_cnt;
    logic [LW-1:0]      fifo_level;

    modport slave (
        input  in_valid, in_op, in_ife, in_rd, in_data, reg_ack,
        output in_ready, reg_update, reg_addr, reg_new, pc_update, pc_new,
               retire_cnt, fifo_level
    );

    modport master (
        output in_valid, in_op, in_ife, in_rd, in_data, reg_ack,
        input  in_ready, reg_update, reg_addr, reg_new, pc_update, pc_new,
               retire_cnt, fifo_level
    );
endinterface

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: decodes accepted instructions into buffered
// register-file writes (show-ahead FIFO) or single-cycle PC redirect pulses.
module wb_retire_unit #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int DROP_R0 = 1
) (
    input logic            clk,
    input logic            rst,
    wb_retire_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [RADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [LW-1:0]      r_level;
    logic [RADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0]  r_last_data;
    logic               r_pc_upd_p1;
    logic [DATA_W-1:0]  r_pc_new_p1;
    logic [CNT_W-1:0]   r_cnt_p1;

    logic w_ready;
    logic w_accept;
    logic w_is_reg;
    logic w_is_pc;
    logic w_drop;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Stage p0: decode the presented instruction and form push/pop strobes
    assign w_ready  = (r_level != LW'(DEPTH));
    assign w_accept = bus.in_valid && w_ready;
    assign w_is_reg = (bus.in_op[5:4] == 2'b00) || (bus.in_op == 6'b010001);
    assign w_is_pc  = ((bus.in_op == 6'b100000) && bus.in_ife) || (bus.in_op == 6'b100001);
    assign w_drop   = (DROP_R0 != 0) && (bus.in_rd == '0);
    assign w_empty  = (r_level == '0);
    assign w_push   = w_accept && w_is_reg && !w_drop;
    assign w_pop    = !w_empty && bus.reg_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr      <= r_rptr + AW'(1);
                r_last_addr <= r_mem_addr[r_rptr];
                r_last_data <= r_mem_data[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= bus.in_rd;
            r_mem_data[r_wptr] <= bus.in_data;
        end
    end

    // Stage p1: registered redirect pulse, target and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_upd_p1 <= 1'b0;
            r_pc_new_p1 <= '0;
            r_cnt_p1    <= '0;
        end else begin
            r_pc_upd_p1 <= w_accept && w_is_pc;
            if (w_accept && w_is_pc) begin
                r_pc_new_p1 <= bus.in_data;
            end
            if (w_accept) begin
                r_cnt_p1 <= r_cnt_p1 + CNT_W'(1);
            end
        end
    end

    // An empty FIFO keeps showing the last popped entry.
    assign bus.in_ready   = w_ready;
    assign bus.reg_update = !w_empty;
    assign bus.reg_addr   = w_empty ? r_last_addr : r_mem_addr[r_rptr];
    assign bus.reg_new    = w_empty ? r_last_data : r_mem_data[r_rptr];
    assign bus.pc_update  = r_pc_upd_p1;
    assign bus.pc_new     = r_pc_new_p1;
    assign bus.retire_cnt = r_cnt_p1;
    assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: a vector table for single-cycle behaviour
// plus hand sequences for fill/drain, push-with-pop, mid-run reset and wrap.
module tb_wb_retire_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_retire_unit_if #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .CNT_W(16)) if1 ();
    wb_retire_unit_if #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .CNT_W(4))  if2 ();

    wb_retire_unit #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .CNT_W(16), .DROP_R0(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    wb_retire_unit #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .CNT_W(4), .DROP_R0(0)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic        ife;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        ack;
        logic        e_upd;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_pc;
        logic [31:0] e_pcn;
        logic [15:0] e_cnt;
        logic [2:0]  e_lvl;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic ife,
                                input logic [4:0] rd, input logic [31:0] d, input logic ack,
                                input logic e_upd, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic e_pc,
                                input logic [31:0] e_pcn, input logic [15:0] e_cnt,
                                input logic [2:0] e_lvl, input logic e_rdy);
        vec_t t;
        t.v = v; t.op = op; t.ife = ife; t.rd = rd; t.d = d; t.ack = ack;
        t.e_upd = e_upd; t.e_addr = e_addr; t.e_data = e_data; t.e_pc = e_pc;
        t.e_pcn = e_pcn; t.e_cnt = e_cnt; t.e_lvl = e_lvl; t.e_rdy = e_rdy;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic ife,
                         input logic [4:0] rd, input logic [31:0] d, input logic ack);
        if1.in_valid = v;
        if1.in_op    = op;
        if1.in_ife   = ife;
        if1.in_rd    = rd;
        if1.in_data  = d;
        if1.reg_ack  = ack;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string p, input logic upd, input logic [4:0] addr,
                           input logic [31:0] data, input logic pc, input logic [31:0] pcn,
                           input logic [15:0] cnt, input logic [2:0] lvl, input logic rdy);
        chk({p, ".reg_update"}, 64'(if1.reg_update), 64'(upd));
        chk({p, ".reg_addr"},   64'(if1.reg_addr),   64'(addr));
        chk({p, ".reg_new"},    64'(if1.reg_new),    64'(data));
        chk({p, ".pc_update"},  64'(if1.pc_update),  64'(pc));
        chk({p, ".pc_new"},     64'(if1.pc_new),     64'(pcn));
        chk({p, ".retire_cnt"}, 64'(if1.retire_cnt), 64'(cnt));
        chk({p, ".fifo_level"}, 64'(if1.fifo_level), 64'(lvl));
        chk({p, ".in_ready"},   64'(if1.in_ready),   64'(rdy));
    endtask

    initial begin
        vecs[0]  = mk(1, 6'b000011, 0, 5, 32'h1234, 1,  1, 5, 32'h1234, 0, 32'h0,   1, 1, 1);
        vecs[1]  = mk(0, 6'b000000, 0, 0, 32'h0,    1,  0, 5, 32'h1234, 0, 32'h0,   1, 0, 1);
        vecs[2]  = mk(1, 6'b100000, 0, 0, 32'h40,   1,  0, 5, 32'h1234, 0, 32'h0,   2, 0, 1);
        vecs[3]  = mk(1, 6'b100000, 1, 0, 32'h80,   1,  0, 5, 32'h1234, 1, 32'h80,  3, 0, 1);
        vecs[4]  = mk(0, 6'b000000, 0, 0, 32'h0,    1,  0, 5, 32'h1234, 0, 32'h80,  3, 0, 1);
        vecs[5]  = mk(1, 6'b100001, 0, 0, 32'h100,  1,  0, 5, 32'h1234, 1, 32'h100, 4, 0, 1);
        vecs[6]  = mk(1, 6'b100001, 1, 0, 32'h200,  1,  0, 5, 32'h1234, 1, 32'h200, 5, 0, 1);
        vecs[7]  = mk(0, 6'b000000, 0, 0, 32'h0,    1,  0, 5, 32'h1234, 0, 32'h200, 5, 0, 1);
        vecs[8]  = mk(1, 6'b110000, 0, 3, 32'h55,   1,  0, 5, 32'h1234, 0, 32'h200, 6, 0, 1);
        vecs[9]  = mk(1, 6'b010001, 0, 0, 32'hFF,   0,  0, 5, 32'h1234, 0, 32'h200, 7, 0, 1);
        vecs[10] = mk(1, 6'b010001, 0, 7, 32'h77,   0,  1, 7, 32'h77,   0, 32'h200, 8, 1, 1);
        vecs[11] = mk(0, 6'b000000, 0, 0, 32'h0,    1,  0, 7, 32'h77,   0, 32'h200, 8, 0, 1);
        vecs[12] = mk(0, 6'b000001, 0, 9, 32'h99,   1,  0, 7, 32'h77,   0, 32'h200, 8, 0, 1);
        vecs[13] = mk(1, 6'b010000, 0, 6, 32'h66,   1,  0, 7, 32'h77,   0, 32'h200, 9, 0, 1);

        drive(0, 6'b0, 0, 0, 32'h0, 0);
        if2.in_valid = 0; if2.in_op = 6'b0; if2.in_ife = 0;
        if2.in_rd = 0; if2.in_data = 32'h0; if2.reg_ack = 0;

        rst = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].ife, vecs[i].rd, vecs[i].d, vecs[i].ack);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_upd, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_pc, vecs[i].e_pcn, vecs[i].e_cnt, vecs[i].e_lvl, vecs[i].e_rdy);
        end

        // Fill to DEPTH with the register file stalled.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 6'b000001, 0, 5'(k), 32'h11 * k, 0);
            tick();
            chk($sformatf("fill%0d.level", k), 64'(if1.fifo_level), 64'(k));
            chk($sformatf("fill%0d.cnt", k),   64'(if1.retire_cnt), 64'(9 + k));
            chk($sformatf("fill%0d.ready", k), 64'(if1.in_ready),   64'(k < 4));
            chk($sformatf("fill%0d.head", k),  64'(if1.reg_addr),   64'd1);
        end
        drive(1, 6'b000001, 0, 9, 32'h99, 0);
        tick();
        chk("full_hold.cnt",   64'(if1.retire_cnt), 64'd13);
        chk("full_hold.level", 64'(if1.fifo_level), 64'd4);
        drive(1, 6'b000001, 0, 9, 32'h99, 1);
        tick();
        chk("full_pop.cnt",   64'(if1.retire_cnt), 64'd13);
        chk("full_pop.level", 64'(if1.fifo_level), 64'd3);
        chk("full_pop.ready", 64'(if1.in_ready),   64'd1);
        chk("full_pop.addr",  64'(if1.reg_addr),   64'd2);
        chk("full_pop.data",  64'(if1.reg_new),    64'h22);
        drive(0, 6'b0, 0, 0, 32'h0, 1);
        for (int k = 3; k <= 4; k++) begin
            tick();
            chk($sformatf("drain%0d.addr", k),  64'(if1.reg_addr),   64'(k));
            chk($sformatf("drain%0d.data", k),  64'(if1.reg_new),    64'(32'h11 * k));
            chk($sformatf("drain%0d.level", k), 64'(if1.fifo_level), 64'(5 - k));
        end
        tick();
        chk_all("drained", 0, 4, 32'h44, 0, 32'h200, 13, 0, 1);

        // Push and pop in the same cycle at level 2.
        drive(1, 6'b000000, 0, 10, 32'hA0, 0);
        tick();
        drive(1, 6'b000000, 0, 11, 32'hB0, 0);
        tick();
        chk("pp_pre.level", 64'(if1.fifo_level), 64'd2);
        drive(1, 6'b000010, 0, 12, 32'hC0, 1);
        tick();
        chk_all("pp_same", 1, 11, 32'hB0, 0, 32'h200, 16, 2, 1);
        drive(0, 6'b0, 0, 0, 32'h0, 1);
        tick();
        chk_all("pp_pop1", 1, 12, 32'hC0, 0, 32'h200, 16, 1, 1);
        tick();
        chk_all("pp_pop2", 0, 12, 32'hC0, 0, 32'h200, 16, 0, 1);
        tick();
        chk_all("ack_empty", 0, 12, 32'hC0, 0, 32'h200, 16, 0, 1);

        // Reset with three entries pending and a redirect pulse in flight.
        for (int k = 13; k <= 15; k++) begin
            drive(1, 6'b000001, 0, 5'(k), 32'(k), 0);
            tick();
        end
        drive(1, 6'b100001, 0, 0, 32'hDEAD, 0);
        tick();
        chk_all("pre_rst", 1, 13, 32'hD, 1, 32'hDEAD, 20, 3, 1);
        drive(0, 6'b0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all("post_rst", 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);

        // Narrow counter instance: r0 is a real write here, then wrap at 16.
        if2.in_valid = 1; if2.in_op = 6'b000000; if2.in_rd = 0; if2.in_data = 32'h5A;
        if2.reg_ack = 0;
        tick();
        chk("r0kept.upd",  64'(if2.reg_update), 64'd1);
        chk("r0kept.addr", 64'(if2.reg_addr),   64'd0);
        chk("r0kept.data", 64'(if2.reg_new),    64'h5A);
        chk("r0kept.cnt",  64'(if2.retire_cnt), 64'd1);
        if2.in_op = 6'b111111;
        if2.reg_ack = 1;
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk($sformatf("wrap%0d.cnt", i), 64'(if2.retire_cnt), 64'(i % 16));
        end
        chk("wrap.level", 64'(if2.fifo_level), 64'd0);
        if2.in_valid = 0;
        tick();
        chk("wrap_idle.cnt", 64'(if2.retire_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_retire_unit.md
Name: wb_retire_unit

Overview:
- Parametrised, pipelined successor to the combinational writeback stage of the multicycle CPU.
- Accepts executed instructions on a valid/ready handshake and decodes them into register-file writes or PC redirects.
- Register-file writes are buffered in a DEPTH-entry FIFO drained under register-file backpressure.
- PC redirects are registered single-cycle pulses; a wrapping retire counter is maintained.

Parameters:
- DATA_W, 32, width of result/PC data
- RADDR_W, 5, destination register index width
- DEPTH, 4, register-write FIFO entries; power of two, >=2
- CNT_W, 16, retire counter width
- DROP_R0, 1, when 1, writes to register 0 are discarded (still retired)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  unit can accept; equals !fifo_full
- in_op  input  6  opcode
- in_ife  input  1  branch-condition flag
- in_rd  input  RADDR_W  destination register
- in_data  input  DATA_W  result / target address (write_i)
- reg_update  output  1  register write request (FIFO non-empty)
- reg_addr  output  RADDR_W  head entry register index
- reg_new  output  DATA_W  head entry data
- reg_ack  input  1  register file accepts head this cycle
- pc_update  output  1  one-cycle redirect pulse
- pc_new  output  DATA_W  redirect target, held between redirects
- retire_cnt  output  CNT_W  accepted-instruction count
- fifo_level  output  $clog2(DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, reg_update=0, reg_addr=0, reg_new=0, pc_update=0, pc_new=0, retire_cnt=0; in_ready=1 after reset.
- Accept = in_valid && in_ready. in_op, in_ife, in_rd and in_data are sampled only on accept; otherwise ignored.
- Decode classes, mutually exclusive:
  - REG: in_op[5:4]==2'b00 or in_op==6'b010001.
  - PC: (in_op==6'b100000 && in_ife) or in_op==6'b100001.
  - NONE: everything else, including 100000 with in_ife=0.
- REG on accept: push {in_rd, in_data}, unless DROP_R0==1 and in_rd==0, in which case nothing is pushed.
- PC on accept: pc_update=1 in the next cycle only; pc_new<=in_data at the same edge and holds until the next PC accept. Back-to-back PC accepts give pc_update high on consecutive cycles with updated pc_new each cycle.
- retire_cnt increments by 1 on every accept (any class, including dropped r0 writes); wraps from 2^CNT_W-1 to 0.
- FIFO is show-ahead:
  - reg_update = !empty; reg_addr/reg_new show the head entry.
  - Pop on reg_update && reg_ack.
  - reg_ack while empty has no effect.
  - When empty, reg_addr/reg_new hold their last values (0 after reset).
- Latency: an entry pushed at edge N is visible on reg_* from cycle N+1. There is no combinational bypass from in_* to reg_*.
- Occupancy rules:
  - Simultaneous push and pop: level unchanged, order preserved.
  - Full: in_ready=0, so no accept occurs even if a pop happens the same cycle. in_ready rises the cycle after the pop.
  - Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- Entries leave in strict arrival order. PC redirects do not flush or reorder pending register writes.
- Reset asserted mid-operation: all pending FIFO entries are discarded, any pending pc_update pulse is cancelled, and all outputs take reset values immediately.

Test Plan:
- Reset, then accept op=000011, rd=5, data=0x1234, reg_ack=1 -> next cycle reg_update=1, reg_addr=5, reg_new=0x1234; following cycle reg_update=0, retire_cnt=1.
- Accept op=100000, ife=0, data=0x40 -> pc_update stays 0, pc_new=0, retire_cnt=1; then op=100000, ife=1, data=0x80 -> pc_update=1 for exactly one cycle, pc_new=0x80 held after.
- reg_ack=0; push 4 REG entries rd=1..4 -> fifo_level=4, in_ready=0; drive in_valid one more cycle -> no accept, retire_cnt=4. Raise reg_ack -> rd 1,2,3,4 drain in order; in_ready=1 the cycle after the first pop.
- DROP_R0=1: accept op=010001, rd=0, data=0xFF -> no reg_update, retire_cnt increments. Then rd=7 -> written normally.
- Level 2 with reg_ack=1 and a REG accept in the same cycle -> fifo_level stays 2, order preserved. Assert rst with 3 entries pending -> fifo_level=0, reg_update=0 immediately.
- Preload retire_cnt near wrap (CNT_W=4): 16 accepts -> retire_cnt returns to 0.
